// File: rtl/barrel_shifter_pipe.sv
// barrel_shifter_pipe: pipelined barrel shifter with one stage per shift-amount bit
// and a valid/ready handshake on both sides.
module barrel_shifter_pipe #(
  parameter int WIDTH = 8,
  parameter int TAG_W = 4,
  localparam int SHW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW-1:0]   in_shift,
  input  logic [1:0]       in_mode,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [TAG_W-1:0] out_tag
);
  logic [SHW-1:0]   v;
  logic [WIDTH-1:0] d  [SHW];
  logic [SHW-1:0]   sh [SHW];
  logic [1:0]       md [SHW];
  logic [TAG_W-1:0] tg [SHW];
  logic             sg [SHW];
  logic             unused;
  for (genvar k = 0; k < SHW; k++) begin : g
    localparam int S = 1 << k;
    logic             uv, usg, ld;
    logic [WIDTH-1:0] ud, r;
    logic [SHW-1:0]   ush;
    logic [1:0]       um;
    logic [TAG_W-1:0] ut;
    if (k == 0) begin : g_src
      assign uv  = in_valid;
      assign ud  = in_data;
      assign ush = in_shift;
      assign um  = in_mode;
      assign ut  = in_tag;
      assign usg = in_data[WIDTH-1];
    end else begin : g_src
      assign uv  = v[k-1];
      assign ud  = d[k-1];
      assign ush = sh[k-1];
      assign um  = md[k-1];
      assign ut  = tg[k-1];
      assign usg = sg[k-1];
    end
    // A stage can load unless it and every stage after it are full and stalled.
    assign ld = out_ready || !(&v[SHW-1:k]);
    always_comb
      r = !ush[0]     ? ud :
          um == 2'd0  ? (ud >> S) | (ud << (WIDTH - S)) :
          um == 2'd1  ? (ud << S) | (ud >> (WIDTH - S)) :
          (ud >> S) | ((um[0] && usg) ? ~({WIDTH{1'b1}} >> S) : '0);
    always_ff @(posedge clk)
      if (rst) begin
        v[k]  <= 1'b0;
        d[k]  <= '0;
        sh[k] <= '0;
        md[k] <= '0;
        tg[k] <= '0;
        sg[k] <= 1'b0;
      end else if (ld) begin
        v[k] <= uv;
        if (uv) begin
          d[k]  <= r;
          sh[k] <= ush >> 1;
          md[k] <= um;
          tg[k] <= ut;
          sg[k] <= usg;
        end
      end
  end
  assign in_ready  = out_ready || !(&v);
  assign out_valid = v[SHW-1];
  assign out_data  = d[SHW-1];
  assign out_tag   = tg[SHW-1];
  assign unused    = ^{sh[SHW-1], md[SHW-1], sg[SHW-1]};
endmodule

// File: tb/tb_barrel_shifter_pipe.sv
// tb_barrel_shifter_pipe: directed and model-checked bench for an 8-bit and a 32-bit shifter.
module tb_barrel_shifter_pipe;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;
  logic a_valid, a_ready, a_ovalid, a_oready;
  logic [7:0] a_data, a_odata;
  logic [2:0] a_shift;
  logic [1:0] a_mode;
  logic [3:0] a_tag, a_otag;
  logic b_valid, b_ready, b_ovalid, b_oready;
  logic [31:0] b_data, b_odata;
  logic [4:0] b_shift;
  logic [1:0] b_mode;
  logic [0:0] b_tag, b_otag;
  int checks = 0;
  int errors = 0;
  logic [31:0] qd[$];
  logic [3:0] qt[$];

  barrel_shifter_pipe #(.WIDTH(8), .TAG_W(4)) u8 (
    .clk(clk), .rst(rst), .in_valid(a_valid), .in_ready(a_ready), .in_data(a_data),
    .in_shift(a_shift), .in_mode(a_mode), .in_tag(a_tag), .out_valid(a_ovalid),
    .out_ready(a_oready), .out_data(a_odata), .out_tag(a_otag));

  barrel_shifter_pipe #(.WIDTH(32), .TAG_W(1)) u32 (
    .clk(clk), .rst(rst), .in_valid(b_valid), .in_ready(b_ready), .in_data(b_data),
    .in_shift(b_shift), .in_mode(b_mode), .in_tag(b_tag), .out_valid(b_ovalid),
    .out_ready(b_oready), .out_data(b_odata), .out_tag(b_otag));

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] model(input logic [31:0] x, input int s, input logic [1:0] m, input int w);
    logic [31:0] msk, y;
    msk = (w == 32) ? 32'hFFFF_FFFF : (32'h1 << w) - 32'h1;
    y = x & msk;
    case (m)
      2'd0: model = ((y >> s) | (y << (w - s))) & msk;
      2'd1: model = ((y << s) | (y >> (w - s))) & msk;
      2'd2: model = y >> s;
      default: model = (y >> s) | (y[w-1] ? (msk & ~(msk >> s)) : 32'h0);
    endcase
  endfunction

  task automatic test_reset;
    rst = 1'b1;
    a_valid = 1'b0; a_oready = 1'b1;
    b_valid = 1'b0; b_oready = 1'b1;
    step; step;
    checks++; if (a_ovalid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", a_ovalid); end
    checks++; if (a_odata !== 8'h00) begin errors++; $display("FAIL reset_data got %h want 00", a_odata); end
    checks++; if (a_otag !== 4'h0) begin errors++; $display("FAIL reset_tag got %h want 0", a_otag); end
    checks++; if (b_ovalid !== 1'b0) begin errors++; $display("FAIL reset_valid32 got %b want 0", b_ovalid); end
    rst = 1'b0;
    step;
    checks++; if (a_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", a_ready); end
  endtask

  task automatic test_modes;
    logic [7:0] vx [9] = '{8'h96, 8'h96, 8'h96, 8'h96, 8'h56, 8'hA5, 8'hA5, 8'hA5, 8'hA5};
    logic [2:0] vs [9] = '{3'd1, 3'd3, 3'd4, 3'd2, 3'd2, 3'd0, 3'd0, 3'd0, 3'd0};
    logic [1:0] vm [9] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3};
    logic [3:0] vt [9] = '{4'h3, 4'h5, 4'h6, 4'h9, 4'hA, 4'hC, 4'hD, 4'hE, 4'hF};
    logic [7:0] ve [9] = '{8'h4B, 8'hB4, 8'h09, 8'hE5, 8'h15, 8'hA5, 8'hA5, 8'hA5, 8'hA5};
    a_oready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      a_valid = 1'b1; a_data = vx[i]; a_shift = vs[i]; a_mode = vm[i]; a_tag = vt[i];
      step;
      a_valid = 1'b0;
      for (int c = 1; c <= 3; c++) begin
        if (c > 1) step;
        checks++;
        if (a_ovalid !== (c == 3)) begin errors++; $display("FAIL mode%0d_latency cycle %0d got valid %b", i, c, a_ovalid); end
      end
      checks++; if (a_odata !== ve[i]) begin errors++; $display("FAIL mode%0d_data got %h want %h", i, a_odata, ve[i]); end
      checks++; if (a_otag !== vt[i]) begin errors++; $display("FAIL mode%0d_tag got %h want %h", i, a_otag, vt[i]); end
      step;
    end
  endtask

  task automatic test_back_to_back;
    a_oready = 1'b1;
    qd.delete(); qt.delete();
    for (int i = 0; i < 20; i++) begin
      if (i < 16) begin
        a_valid = 1'b1; a_data = 8'($urandom); a_shift = 3'($urandom); a_mode = 2'($urandom); a_tag = 4'($urandom);
        #1;
        checks++; if (a_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready op %0d got %b want 1", i, a_ready); end
        qd.push_back(model({24'h0, a_data}, int'(a_shift), a_mode, 8));
        qt.push_back(a_tag);
      end else a_valid = 1'b0;
      step;
      checks++;
      if (a_ovalid !== (i >= 2 && i < 18)) begin errors++; $display("FAIL b2b_valid cycle %0d got %b", i, a_ovalid); end
      else if (a_ovalid) begin
        checks++; if ({24'h0, a_odata} !== qd[0]) begin errors++; $display("FAIL b2b_data cycle %0d got %h want %h", i, a_odata, qd[0][7:0]); end
        checks++; if (a_otag !== qt[0]) begin errors++; $display("FAIL b2b_tag cycle %0d got %h want %h", i, a_otag, qt[0]); end
        void'(qd.pop_front()); void'(qt.pop_front());
      end
    end
  endtask

  task automatic test_backpressure;
    logic [7:0] px [4] = '{8'h81, 8'h0F, 8'hF0, 8'hF0};
    logic [2:0] ps [4] = '{3'd1, 3'd2, 3'd3, 3'd3};
    logic [1:0] pm [4] = '{2'd0, 2'd1, 2'd3, 2'd2};
    logic [3:0] pt [4] = '{4'h1, 4'h2, 4'h4, 4'h5};
    logic [7:0] pe [4] = '{8'hC0, 8'h3C, 8'hFE, 8'h1E};
    logic [7:0] sd;
    logic [3:0] st;
    logic snap, acc;
    int idx, got;
    idx = 0; got = 0; snap = 1'b0;
    a_oready = 1'b0;
    a_valid = 1'b1; a_data = px[0]; a_shift = ps[0]; a_mode = pm[0]; a_tag = pt[0];
    #1;
    for (int c = 0; c < 6; c++) begin
      acc = a_valid && a_ready;
      step;
      if (acc) idx++;
      if (idx < 4) begin a_valid = 1'b1; a_data = px[idx]; a_shift = ps[idx]; a_mode = pm[idx]; a_tag = pt[idx]; end
      else a_valid = 1'b0;
      if (a_ovalid) begin
        if (snap) begin
          checks++; if (a_odata !== sd || a_otag !== st) begin errors++; $display("FAIL stall_hold cycle %0d got %h/%h want %h/%h", c, a_odata, a_otag, sd, st); end
        end else begin sd = a_odata; st = a_otag; snap = 1'b1; end
      end
    end
    checks++; if (idx != 3) begin errors++; $display("FAIL stall_accepts got %0d want 3", idx); end
    checks++; if (a_ready !== 1'b0) begin errors++; $display("FAIL stall_ready got %b want 0", a_ready); end
    checks++; if (a_ovalid !== 1'b1) begin errors++; $display("FAIL stall_valid got %b want 1", a_ovalid); end
    a_oready = 1'b1;
    #1;
    for (int c = 0; c < 12; c++) begin
      if (a_ovalid) begin
        checks++;
        if (got >= 4) begin errors++; $display("FAIL drain_extra got result %h beyond 4", a_odata); end
        else if (a_odata !== pe[got] || a_otag !== pt[got]) begin
          errors++; $display("FAIL drain_order %0d got %h/%h want %h/%h", got, a_odata, a_otag, pe[got], pt[got]);
        end
        got++;
      end
      acc = a_valid && a_ready;
      step;
      if (acc) idx++;
      if (idx < 4) begin a_valid = 1'b1; a_data = px[idx]; a_shift = ps[idx]; a_mode = pm[idx]; a_tag = pt[idx]; end
      else a_valid = 1'b0;
    end
    checks++; if (got != 4) begin errors++; $display("FAIL drain_count got %0d want 4", got); end
  endtask

  task automatic test_reset_mid;
    a_oready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      a_valid = 1'b1; a_data = 8'h5A + 8'(i); a_shift = 3'd1; a_mode = 2'd0; a_tag = 4'h7;
      step;
    end
    rst = 1'b1;
    a_data = 8'hFF; a_tag = 4'hB;
    step;
    checks++; if (a_ovalid !== 1'b0) begin errors++; $display("FAIL midrst_valid got %b want 0", a_ovalid); end
    checks++; if (a_odata !== 8'h00) begin errors++; $display("FAIL midrst_data got %h want 00", a_odata); end
    checks++; if (a_otag !== 4'h0) begin errors++; $display("FAIL midrst_tag got %h want 0", a_otag); end
    rst = 1'b0;
    a_valid = 1'b0;
    step;
    checks++; if (a_ready !== 1'b1) begin errors++; $display("FAIL midrst_ready got %b want 1", a_ready); end
    for (int c = 0; c < 6; c++) begin
      checks++; if (a_ovalid !== 1'b0) begin errors++; $display("FAIL midrst_stale cycle %0d got valid %b", c, a_ovalid); end
      step;
    end
  endtask

  task automatic test_sweep32;
    int lat, n_acc, n_got;
    logic acc;
    b_oready = 1'b1;
    b_valid = 1'b1; b_data = 32'h8000_0001; b_shift = 5'd31; b_mode = 2'd1; b_tag = 1'b1;
    step;
    b_valid = 1'b0;
    lat = 1;
    while (!b_ovalid && lat < 10) begin step; lat++; end
    checks++; if (lat != 5) begin errors++; $display("FAIL sweep_latency got %0d want 5", lat); end
    checks++; if (b_odata !== 32'hC000_0000 || b_otag !== 1'b1) begin errors++; $display("FAIL sweep_first got %h/%b want c0000000/1", b_odata, b_otag); end
    step;
    qd.delete(); qt.delete();
    n_acc = 0; n_got = 0;
    for (int cyc = 0; cyc < 20000 && n_got < 1000; cyc++) begin
      if (!b_valid && n_acc < 1000) begin
        b_valid = $urandom_range(0, 3) != 0;
        b_data = $urandom; b_shift = 5'($urandom); b_mode = 2'($urandom); b_tag = 1'($urandom);
      end
      b_oready = $urandom_range(0, 3) != 0;
      #1;
      if (b_ovalid && b_oready) begin
        checks++;
        if (qd.size() == 0) begin errors++; $display("FAIL sweep_unexpected got %h", b_odata); end
        else begin
          if (b_odata !== qd[0] || {3'b0, b_otag} !== qt[0]) begin
            errors++; $display("FAIL sweep_result %0d got %h/%b want %h/%b", n_got, b_odata, b_otag, qd[0], qt[0][0]);
          end
          void'(qd.pop_front()); void'(qt.pop_front());
        end
        n_got++;
      end
      acc = b_valid && b_ready;
      if (acc) begin
        qd.push_back(model(b_data, int'(b_shift), b_mode, 32));
        qt.push_back({3'b0, b_tag});
      end
      step;
      if (acc) begin n_acc++; b_valid = 1'b0; end
    end
    checks++; if (n_got != 1000) begin errors++; $display("FAIL sweep_count got %0d want 1000", n_got); end
    checks++; if (qd.size() != 0) begin errors++; $display("FAIL sweep_leftover got %0d want 0", qd.size()); end
  endtask

  initial begin
    test_reset;
    test_modes;
    test_back_to_back;
    test_backpressure;
    test_reset_mid;
    test_sweep32;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
